rggen_apb_register_bridge: RTL and testbench

RGGEN_APB_REGISTER_BRIDGE -- requirements
Module: rggen_apb_register_bridge

---
 rtl/rggen_apb_register_bridge.sv | 169 ++++++++++++++++
 tb/tb_rggen_apb_register_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_apb_register_bridge.sv
// rggen_apb_register_bridge
// APB slave that maps a small array of downstream registers onto a byte-addressed
// window starting at BASE_ADDRESS. Each transfer costs one wait state: the setup
// phase is captured, the access phase fires a one-cycle per-register strobe, and
// the following cycle returns pready with the response.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_psel/i_penable/i_pwrite       APB control
//   i_paddr, i_pwdata, i_pstrb      APB address, write data, byte strobes
//   o_pready, o_pslverr, o_prdata   APB completion, error, read data
//   o_write_access, o_read_access   per-register one-cycle access strobes
//   o_write_data, o_write_mask      shared write data and bit mask
//   i_read_data                     register i value at [i*DATA_WIDTH +: DATA_WIDTH]
//
// state   | meaning
// IDLE    | waiting for an APB setup phase
// ACCESS  | captured transfer, waiting for penable; strobe fires here
// RESPOND | pready driven with the captured response
module rggen_apb_register_bridge #(
    parameter int                         ADDRESS_WIDTH = 16,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         REGISTERS     = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS  = 'h10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_psel,
    input  logic                            i_penable,
    input  logic                            i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0]        i_paddr,
    input  logic [DATA_WIDTH-1:0]           i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]         i_pstrb,
    output logic                            o_pready,
    output logic                            o_pslverr,
    output logic [DATA_WIDTH-1:0]           o_prdata,
    output logic [REGISTERS-1:0]            o_write_access,
    output logic [REGISTERS-1:0]            o_read_access,
    output logic [DATA_WIDTH-1:0]           o_write_data,
    output logic [DATA_WIDTH-1:0]           o_write_mask,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] REG_COUNT = ADDRESS_WIDTH'(REGISTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                     cap_write;
    logic                     cap_hit;
    logic [IDX_W-1:0]         cap_idx;
    logic [DATA_WIDTH-1:0]    cap_wdata;
    logic [STRB_WIDTH-1:0]    cap_strb;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic [ADDRESS_WIDTH-1:0] offset;
    logic [ADDRESS_WIDTH-1:0] word;
    logic                     dec_hit;
    logic [IDX_W-1:0]         dec_idx;

    logic                     setup;
    logic                     enable;
    logic                     access_fire;
    logic                     respond;
    logic [REGISTERS-1:0]     onehot;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [DATA_WIDTH-1:0]    mask_bits;

    // An address below the base wraps to a large offset, so the explicit lower
    // bound check keeps it from aliasing onto a valid register.
    assign offset  = i_paddr - BASE_ADDRESS;
    assign word    = offset >> BYTE_LSB;
    assign dec_hit = (i_paddr >= BASE_ADDRESS) &&
                     (offset[BYTE_LSB-1:0] == '0) &&
                     (word < REG_COUNT);
    assign dec_idx = word[IDX_W-1:0];

    assign setup       = i_psel && !i_penable;
    assign enable      = i_psel && i_penable;
    // Reset gates the strobe in the same cycle, not just the next state.
    assign access_fire = !rst && (state == ACCESS) && enable;
    assign respond     = !rst && (state == RESPOND) && i_psel;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!i_psel) begin
                    state_next = IDLE;
                end else if (i_penable) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_write <= 1'b0;
            cap_hit   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && setup) begin
                cap_write <= i_pwrite;
                cap_hit   <= dec_hit;
                cap_idx   <= dec_idx;
                cap_wdata <= i_pwdata;
                cap_strb  <= i_pstrb;
            end
            if (access_fire && cap_hit && !cap_write) begin
                rdata_q <= sel_data;
            end
        end
    end

    always_comb begin
        onehot   = '0;
        sel_data = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (IDX_W'(i) == cap_idx) begin
                onehot[i] = 1'b1;
                sel_data  = i_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        mask_bits = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            mask_bits[b] = cap_strb[b/8];
        end
    end

    assign o_write_access = (access_fire && cap_hit && cap_write)  ? onehot : '0;
    assign o_read_access  = (access_fire && cap_hit && !cap_write) ? onehot : '0;

    assign o_pready  = respond;
    assign o_pslverr = respond && !cap_hit;
    assign o_prdata  = (respond && cap_hit && !cap_write) ? rdata_q : '0;

    assign o_write_data = rst ? '0 : cap_wdata;
    assign o_write_mask = rst ? '0 : mask_bits;

endmodule

// File: tb/tb_rggen_apb_register_bridge.sv
module tb_rggen_apb_register_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic [3:0]  write_access;
    logic [3:0]  read_access;
    logic [31:0] write_data;
    logic [31:0] write_mask;
    logic [127:0] read_data;

    rggen_apb_register_bridge #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .REGISTERS     (4),
        .BASE_ADDRESS  (16'h0010)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_psel         (psel),
        .i_penable      (penable),
        .i_pwrite       (pwrite),
        .i_paddr        (paddr),
        .i_pwdata       (pwdata),
        .i_pstrb        (pstrb),
        .o_pready       (pready),
        .o_pslverr      (pslverr),
        .o_prdata       (prdata),
        .o_write_access (write_access),
        .o_read_access  (read_access),
        .o_write_data   (write_data),
        .o_write_mask   (write_mask),
        .i_read_data    (read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream register file model.
    logic [31:0] regs [4] = '{32'hCAFE_F00D, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0000};
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (write_access[i]) begin
                regs[i] <= (regs[i] & ~write_mask) | (write_data & write_mask);
            end
        end
    end
    assign read_data = {regs[3], regs[2], regs[1], regs[0]};

    typedef struct {
        int          cyc;
        logic [3:0]  wr;
        logic [3:0]  rd;
        logic [31:0] wdata;
        logic [31:0] mask;
    } stb_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    stb_t stb_q[$];
    rsp_t rsp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe or pready.
    stb_t se;
    rsp_t re;
    always @(negedge clk) begin
        if (!rst) begin
            while (stb_q.size() > 0 && stb_q[0].cyc < cyc) begin
                se = stb_q.pop_front();
                chk("missing_strobe", 64'(cyc), 64'(se.cyc));
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                re = rsp_q.pop_front();
                chk("missing_pready", 64'(cyc), 64'(re.cyc));
            end
            if (write_access != 4'd0 || read_access != 4'd0) begin
                if (stb_q.size() == 0) begin
                    chk("unexpected_strobe", {56'd0, write_access, read_access}, 64'd0);
                end else begin
                    se = stb_q.pop_front();
                    chk("strobe_cycle",  64'(cyc), 64'(se.cyc));
                    chk("write_access",  64'(write_access), 64'(se.wr));
                    chk("read_access",   64'(read_access), 64'(se.rd));
                    chk("write_data",    64'(write_data), 64'(se.wdata));
                    chk("write_mask",    64'(write_mask), 64'(se.mask));
                    chk("strobe_onehot", 64'($countones({write_access, read_access})), 64'd1);
                end
            end
            if (pready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_pready", 64'(pready), 64'd0);
                end else begin
                    re = rsp_q.pop_front();
                    chk("pready_cycle", 64'(cyc), 64'(re.cyc));
                    chk("prdata",       64'(prdata), 64'(re.rdata));
                    chk("pslverr",      64'(pslverr), 64'(re.err));
                end
            end else if (prdata != 32'd0 || pslverr) begin
                chk("idle_response", {31'd0, pslverr, prdata}, 64'd0);
            end
        end
    end

    // Issues one transfer starting in the current cycle. exp_vec = 0 means no strobe.
    task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] exp_vec,
                        input logic [31:0] exp_mask, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic abort);
        stb_t st;
        rsp_t rp;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        if (!abort) begin
            if (exp_vec != 4'd0) begin
                st.cyc   = cyc + 1;
                st.wr    = w ? exp_vec : 4'd0;
                st.rd    = w ? 4'd0 : exp_vec;
                st.wdata = d;
                st.mask  = exp_mask;
                stb_q.push_back(st);
            end
            rp.cyc   = cyc + 2;
            rp.rdata = exp_rdata;
            rp.err   = exp_err;
            rsp_q.push_back(rp);
        end
        @(posedge clk); #1;
        if (abort) begin
            psel    = 1'b0;
            penable = 1'b0;
            @(posedge clk); #1;
        end else begin
            penable = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pready",   64'(pready), 64'd0);
        chk("reset_strobes",  64'({write_access, read_access}), 64'd0);
        chk("reset_wdata",    64'(write_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_outputs", {pready, pslverr, write_access, read_access, write_mask[21:0]}, 64'd0);
        chk("post_reset_wdata",   64'(write_data), 64'd0);

        // addr, wr, data, strb, vec, mask, rdata, err, abort
        xfer(16'h0010, 1, 32'hA5A5_1234, 4'b0011, 4'b0001, 32'h0000_FFFF, 32'h0, 0, 0);
        xfer(16'h0018, 0, 32'h0,         4'b0000, 4'b0100, 32'h0,         32'hDEAD_BEEF, 0, 0);
        xfer(16'h0020, 0, 32'h0,         4'b0000, 4'b0000, 32'h0,         32'h0, 1, 0);
        xfer(16'h0012, 1, 32'h5555_AAAA, 4'b1111, 4'b0000, 32'h0,         32'h0, 1, 0);
        // back-to-back write then read of the same register
        xfer(16'h001C, 1, 32'h1234_5678, 4'b1111, 4'b1000, 32'hFFFF_FFFF, 32'h0, 0, 0);
        xfer(16'h001C, 0, 32'h0,         4'b0000, 4'b1000, 32'h0,         32'h1234_5678, 0, 0);
        // aborted write must leave register 1 untouched
        xfer(16'h0014, 1, 32'h0BAD_0BAD, 4'b1111, 4'b0000, 32'h0,         32'h0, 0, 1);
        xfer(16'h0014, 0, 32'h0,         4'b0000, 4'b0010, 32'h0,         32'h1111_1111, 0, 0);
        // zero-strobe write still strobes but changes nothing
        xfer(16'h0014, 1, 32'hFFFF_FFFF, 4'b0000, 4'b0010, 32'h0000_0000, 32'h0, 0, 0);
        xfer(16'h0014, 0, 32'h0,         4'b0000, 4'b0010, 32'h0,         32'h1111_1111, 0, 0);
        xfer(16'h0010, 0, 32'h0,         4'b0000, 4'b0001, 32'h0,         32'hCAFE_1234, 0, 0);
        xfer(16'h000C, 0, 32'h0,         4'b0000, 4'b0000, 32'h0,         32'h0, 1, 0);
        xfer(16'h0011, 0, 32'h0,         4'b0000, 4'b0000, 32'h0,         32'h0, 1, 0);

        // penable without a preceding setup is ignored
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0010; pstrb = 4'hF;
        repeat (3) begin
            @(posedge clk); #1;
            chk("penable_idle_pready", 64'({pready, write_access, read_access}), 64'd0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;

        // reset during ACCESS of a write to register 0
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        #2;
        chk("rst_access_strobes", 64'({write_access, read_access}), 64'd0);
        chk("rst_access_outputs", {pready, pslverr, prdata}, 64'd0);
        chk("rst_access_wmask",   64'(write_mask), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // still driving an enable phase: an FSM left in ACCESS would strobe here
        #2;
        chk("rst_release_outputs", {pready, write_access, read_access, write_data[23:0]}, 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(16'h0010, 0, 32'h0, 4'b0000, 4'b0001, 32'h0, 32'hCAFE_1234, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("strobe_queue_drained",   64'(stb_q.size()), 64'd0);
        chk("response_queue_drained", 64'(rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
